// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
// pipe_hazard_ctrl_pkg : shared widths, hazard FSM state codes, load-use check
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_hazard_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int PC_WIDTH   = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [0:0] {
        HZ_IDLE     = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_e;

    // x0 is hard-wired zero, so a load into it never creates a dependency.
    function automatic logic load_use_hit(
        input logic                  is_load,
        input logic [REG_ADDR_W-1:0] dst,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic [REG_ADDR_W-1:0] rs2,
        input logic                  need_rs1,
        input logic                  need_rs2
    );
        return is_load && (dst != '0) &&
               ((need_rs1 && (rs1 == dst)) || (need_rs2 && (rs2 == dst)));
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// ============================================================================
// sat_counter : up-counter that sticks at all-ones
// Revision : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl : stall/flush control for the 5-stage pipeline
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic [4:0]           D_rs1_i,
    input  logic [4:0]           D_rs2_i,
    input  logic                 D_need_rs1_i,
    input  logic                 D_need_rs2_i,
    input  logic                 E_is_load_i,
    input  logic [4:0]           E_dstE_i,
    input  logic                 E_mispredict_i,
    input  logic                 M_mem_en_i,
    input  logic                 dmem_ack_i,
    output logic                 dmem_req_o,
    output logic                 pc_stall_o,
    output logic                 F_stall_o,
    output logic                 F_bubble_o,
    output logic                 D_stall_o,
    output logic                 D_bubble_o,
    output logic                 E_stall_o,
    output logic                 E_bubble_o,
    output logic                 M_stall_o,
    output logic                 M_bubble_o,
    output logic                 mem_err_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    localparam logic [7:0] c_timeout = 8'(MEM_TIMEOUT);

    hz_state_e  state_q;
    hz_state_e  state_d;
    logic [7:0] wait_cnt_q;
    logic [7:0] wait_cnt_d;

    logic w_in_wait;
    logic w_timeout;
    logic w_mem_busy;
    logic w_load_use;
    logic w_flush;
    logic w_lu_stall;

    // Every output is gated by rst_n so nothing leaks while reset is held.
    always_comb begin
        w_in_wait  = (state_q == HZ_MEM_WAIT);
        w_timeout  = w_in_wait && (wait_cnt_q == c_timeout);
        dmem_req_o = rst_n && (w_in_wait || M_mem_en_i);
        w_mem_busy = dmem_req_o && !dmem_ack_i && !w_timeout;
        mem_err_o  = rst_n && w_timeout && !dmem_ack_i;
        w_load_use = load_use_hit(E_is_load_i, E_dstE_i, D_rs1_i, D_rs2_i,
                                  D_need_rs1_i, D_need_rs2_i);
        w_flush    = rst_n && !w_mem_busy && E_mispredict_i;
        w_lu_stall = rst_n && !w_mem_busy && !E_mispredict_i && w_load_use;
    end

    always_comb begin
        pc_stall_o = w_mem_busy || w_lu_stall;
        F_stall_o  = w_mem_busy || w_lu_stall;
        F_bubble_o = w_flush;
        D_stall_o  = w_mem_busy;
        D_bubble_o = w_flush || w_lu_stall;
        E_stall_o  = w_mem_busy;
        E_bubble_o = 1'b0;
        M_stall_o  = 1'b0;
        M_bubble_o = w_mem_busy;
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        case (state_q)
            HZ_IDLE: begin
                if (w_mem_busy) begin
                    state_d    = HZ_MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            HZ_MEM_WAIT: begin
                if (dmem_ack_i || w_timeout) begin
                    state_d = HZ_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = HZ_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HZ_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .inc_i (pc_stall_o),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .inc_i (w_flush),
        .cnt_o (flush_cnt_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// tb_pipe_hazard_ctrl : directed scenarios plus random traffic vs. a reference model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_WIDTH   = 4;
    localparam int CNT_MAX     = (1 << CNT_WIDTH) - 1;

    // bit positions in the packed output vector
    localparam int B_REQ = 10, B_PC = 9, B_FS = 8, B_FB = 7, B_DS = 6, B_DB = 5;
    localparam int B_ES  = 4,  B_EB = 3, B_MS = 2, B_MB = 1, B_ERR = 0;

    logic                 clk;
    logic                 rst_n;
    logic [4:0]           D_rs1, D_rs2, E_dst;
    logic                 D_need_rs1, D_need_rs2, E_is_load, E_mispredict, M_mem_en, dmem_ack;
    logic                 dmem_req, pc_stall, F_stall, F_bubble, D_stall, D_bubble;
    logic                 E_stall, E_bubble, M_stall, M_bubble, mem_err;
    logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state: request cycles already spent on the outstanding access
    int m_age   = 0;
    int m_stall = 0;
    int m_flush = 0;

    logic [10:0] last_vec;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk_i          (clk),
        .rst_n          (rst_n),
        .D_rs1_i        (D_rs1),
        .D_rs2_i        (D_rs2),
        .D_need_rs1_i   (D_need_rs1),
        .D_need_rs2_i   (D_need_rs2),
        .E_is_load_i    (E_is_load),
        .E_dstE_i       (E_dst),
        .E_mispredict_i (E_mispredict),
        .M_mem_en_i     (M_mem_en),
        .dmem_ack_i     (dmem_ack),
        .dmem_req_o     (dmem_req),
        .pc_stall_o     (pc_stall),
        .F_stall_o      (F_stall),
        .F_bubble_o     (F_bubble),
        .D_stall_o      (D_stall),
        .D_bubble_o     (D_bubble),
        .E_stall_o      (E_stall),
        .E_bubble_o     (E_bubble),
        .M_stall_o      (M_stall),
        .M_bubble_o     (M_bubble),
        .mem_err_o      (mem_err),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, check the combinational
    // response against the model, then check the counters after the rising edge.
    task automatic step(input logic rn, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic n1, input logic n2, input logic ld, input logic [4:0] dst,
                        input logic mp, input logic men, input logic ack);
        logic        lu, tmo, req, busy, err, fl, lus;
        logic [10:0] exp_vec;
        @(negedge clk);
        rst_n = rn; D_rs1 = rs1; D_rs2 = rs2; D_need_rs1 = n1; D_need_rs2 = n2;
        E_is_load = ld; E_dst = dst; E_mispredict = mp; M_mem_en = men; dmem_ack = ack;
        if (!rn) begin
            m_age = 0; m_stall = 0; m_flush = 0;
        end
        #1;
        lu   = ld && (dst != 0) && ((n1 && rs1 == dst) || (n2 && rs2 == dst));
        tmo  = (m_age == MEM_TIMEOUT);
        req  = rn && (m_age > 0 || men);
        busy = req && !ack && !tmo;
        err  = rn && tmo && !ack;
        fl   = rn && !busy && mp;
        lus  = rn && !busy && !mp && lu;
        exp_vec = {req, busy | lus, busy | lus, fl, busy, fl | lus, busy, 1'b0, 1'b0, busy, err};
        last_vec = {dmem_req, pc_stall, F_stall, F_bubble, D_stall, D_bubble,
                    E_stall, E_bubble, M_stall, M_bubble, mem_err};
        check_eq("outputs", 32'(last_vec), 32'(exp_vec));
        @(posedge clk);
        if (rn) begin
            m_age = busy ? m_age + 1 : 0;
            if ((busy || lus) && m_stall < CNT_MAX) m_stall++;
            if (fl && m_flush < CNT_MAX) m_flush++;
        end
        #1;
        check_eq("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check_eq("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    endtask

    task automatic idle(input logic rn, input logic men, input logic ack, input logic mp);
        step(rn, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, mp, men, ack);
    endtask

    initial begin
        int req_cycles, stall_cycles, err_pulses;
        rst_n = 1'b0; D_rs1 = '0; D_rs2 = '0; D_need_rs1 = 1'b0; D_need_rs2 = 1'b0;
        E_is_load = 1'b0; E_dst = '0; E_mispredict = 1'b0; M_mem_en = 1'b0; dmem_ack = 1'b0;

        // reset with a memory request pending must not leak dmem_req
        idle(1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("reset_req", 32'(last_vec[B_REQ]), 32'd0);
        idle(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("reset_stall_cnt", 32'(stall_cnt), 32'd0);

        // load x5 in execute, decode reads x5
        step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        check_eq("lu_pc_stall", 32'(last_vec[B_PC]), 32'd1);
        check_eq("lu_d_bubble", 32'(last_vec[B_DB]), 32'd1);
        check_eq("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        idle(1'b1, 1'b0, 1'b0, 1'b0);

        // load into x0 never stalls
        step(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        check_eq("x0_pc_stall", 32'(last_vec[B_PC]), 32'd0);

        // mispredict overrides load-use
        step(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        check_eq("mp_f_bubble", 32'(last_vec[B_FB]), 32'd1);
        check_eq("mp_pc_stall", 32'(last_vec[B_PC]), 32'd0);
        check_eq("mp_flush_cnt", 32'(flush_cnt), 32'd1);

        // memory access acknowledged after 3 wait cycles
        idle(1'b0, 1'b0, 1'b0, 1'b0);
        req_cycles = 0; stall_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            idle(1'b1, 1'b1, (i == 3), 1'b0);
            req_cycles   += int'(last_vec[B_REQ]);
            stall_cycles += int'(last_vec[B_ES] & last_vec[B_MB]);
        end
        check_eq("ack_req_cycles", 32'(req_cycles), 32'd4);
        check_eq("ack_stall_cycles", 32'(stall_cycles), 32'd3);
        check_eq("ack_stall_cnt", 32'(stall_cnt), 32'd3);

        // no ack: timeout in the 5th request cycle, held mispredict then acted on
        idle(1'b0, 1'b0, 1'b0, 1'b0);
        err_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            idle(1'b1, 1'b1, 1'b0, 1'b1);
            err_pulses += int'(last_vec[B_ERR]);
            if (i == 4) check_eq("tmo_err_5th", 32'(last_vec[B_ERR]), 32'd1);
        end
        idle(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("tmo_err_pulses", 32'(err_pulses + int'(last_vec[B_ERR])), 32'd1);
        check_eq("tmo_flush_cnt", 32'(flush_cnt), 32'd1);

        // reset while waiting aborts the access without an error
        idle(1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("abort_req", 32'(last_vec[B_REQ]), 32'd0);
        check_eq("abort_err", 32'(last_vec[B_ERR]), 32'd0);
        idle(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("abort_idle_req", 32'(last_vec[B_REQ]), 32'd0);

        // random traffic, long enough for the narrow counters to saturate
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 79) != 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
